// File: rtl/jtag_dr_chain.sv
// JTAG data-register chain: capture/shift/update on JTCK, with the update
// register mirrored into the clk domain through a toggle synchroniser.

module jtag_dr_tgl_sync (
  input  logic clk,
  input  logic JRSTN,
  input  logic i_tgl,
  output logic o_pulse
);
  // [0],[1] are the metastability pair; [2] holds the previous settled level
  logic [2:0] r_pipe;

  always_ff @(posedge clk or negedge JRSTN) begin
    if (!JRSTN) r_pipe <= '0;
    else        r_pipe <= {r_pipe[1:0], i_tgl};
  end

  assign o_pulse = r_pipe[1] ^ r_pipe[2];
endmodule

module jtag_dr_chain #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [63:0] RESET_VALUE  = 64'd0,
  parameter bit          CAPTURE_SRC  = 1'b0,
  parameter bit          CHECK_LENGTH = 1'b1
) (
  input  logic             JTCK,
  input  logic             clk,
  input  logic             JRSTN,
  input  logic             JTDI,
  input  logic             JCE,
  input  logic             JSHIFT,
  input  logic             JUPDATE,
  input  logic             JSEL,
  input  logic [WIDTH-1:0] status_in,
  output logic             JTDO,
  output logic [WIDTH-1:0] data_out,
  output logic             len_err,
  output logic [WIDTH-1:0] sys_data,
  output logic             sys_valid
);
  localparam int unsigned      CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [WIDTH-1:0] RST_VAL  = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_lerr;
  logic             r_tgl;
  logic [WIDTH-1:0] r_sys_data;
  logic             r_sys_vld;

  logic [WIDTH-1:0] w_cap_val;
  logic             w_upd_req;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_edge;

  assign w_cap_val = CAPTURE_SRC ? status_in : r_dout;
  assign w_upd_req = JUPDATE & JSEL;
  assign w_len_ok  = !CHECK_LENGTH || (r_cnt == CNT_FULL);
  assign w_accept  = w_upd_req & w_len_ok;

  // Update reads pre-edge shift_reg/count, so a capture or shift on the
  // same edge proceeds independently.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= RST_VAL;
      r_lerr  <= 1'b0;
      r_tgl   <= 1'b0;
    end else begin
      if (JCE) begin
        if (JSHIFT) begin
          r_shift <= {JTDI, r_shift[WIDTH-1:1]};
          if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CW'(1);
        end else begin
          r_shift <= w_cap_val;
          r_cnt   <= '0;
        end
      end
      if (w_accept) begin
        r_dout <= r_shift;
        r_lerr <= 1'b0;
        r_tgl  <= ~r_tgl;
      end else if (w_upd_req) begin
        r_lerr <= 1'b1;
      end
    end
  end

  jtag_dr_tgl_sync u_sync (
    .clk    (clk),
    .JRSTN  (JRSTN),
    .i_tgl  (r_tgl),
    .o_pulse(w_edge)
  );

  // data_out is stable for several clk periods around a toggle, so it is
  // sampled directly once the toggle has settled.
  always_ff @(posedge clk or negedge JRSTN) begin
    if (!JRSTN) begin
      r_sys_data <= RST_VAL;
      r_sys_vld  <= 1'b0;
    end else begin
      r_sys_vld <= w_edge;
      if (w_edge) r_sys_data <= r_dout;
    end
  end

  assign JTDO      = r_shift[0];
  assign data_out  = r_dout;
  assign len_err   = r_lerr;
  assign sys_data  = r_sys_data;
  assign sys_valid = r_sys_vld;
endmodule

// File: tb/tb_jtag_dr_chain.sv
// Bench: two chains (readback + length check, status capture + no check)
// driven by one JTAG stream; sys_valid results checked through scoreboards.

module tb_jtag_dr_chain;
  logic JTCK = 1'b0, clk = 1'b0, JRSTN = 1'b0;
  logic JTDI = 1'b0, JCE = 1'b0, JSHIFT = 1'b0, JUPDATE = 1'b0, JSEL = 1'b0;
  logic [7:0] status_in = 8'hC3;
  logic tdo_a, lerr_a, svld_a, tdo_b, lerr_b, svld_b;
  logic [7:0] dout_a, sdata_a, dout_b, sdata_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    time        t;
  } sb_t;
  sb_t qa[$];
  sb_t qb[$];
  sb_t ia, ib;

  typedef struct {
    int          n;
    logic [31:0] bits;
    bit          upd, sel;
    logic [7:0]  tdo_a, tdo_b, dout_a;
    bit          lerr_a, acc_a;
    logic [7:0]  dout_b;
    bit          acc_b;
  } vec_t;
  vec_t vt[11];

  always #20 JTCK = ~JTCK;
  always #5  clk  = ~clk;

  jtag_dr_chain #(.WIDTH(8), .RESET_VALUE(64'h81), .CAPTURE_SRC(1'b0), .CHECK_LENGTH(1'b1)) u_a (
    .JTCK(JTCK), .clk(clk), .JRSTN(JRSTN), .JTDI(JTDI), .JCE(JCE), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .JSEL(JSEL), .status_in(status_in), .JTDO(tdo_a),
    .data_out(dout_a), .len_err(lerr_a), .sys_data(sdata_a), .sys_valid(svld_a)
  );

  jtag_dr_chain #(.WIDTH(8), .RESET_VALUE(64'h0), .CAPTURE_SRC(1'b1), .CHECK_LENGTH(1'b0)) u_b (
    .JTCK(JTCK), .clk(clk), .JRSTN(JRSTN), .JTDI(JTDI), .JCE(JCE), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .JSEL(JSEL), .status_in(status_in), .JTDO(tdo_b),
    .data_out(dout_b), .len_err(lerr_b), .sys_data(sdata_b), .sys_valid(svld_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected latency from the update edge to the sampled pulse: 3-4 clk.
  always @(negedge clk) begin
    if (svld_a === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL sysv_a_spurious: got pulse expected none");
      end else begin
        ia = qa.pop_front();
        chk("sysd_a", sdata_a, ia.d);
        chk("lat_a", (($time - ia.t) >= 20) && (($time - ia.t) <= 50), 1);
      end
    end
    if (svld_b === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL sysv_b_spurious: got pulse expected none");
      end else begin
        ib = qb.pop_front();
        chk("sysd_b", sdata_b, ib.d);
        chk("lat_b", (($time - ib.t) >= 20) && (($time - ib.t) <= 50), 1);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge JTCK);
      JCE = 0; JSHIFT = 0; JUPDATE = 0; JSEL = 0; JTDI = 0;
    end
  endtask

  task automatic capture();
    @(negedge JTCK);
    JCE = 1; JSHIFT = 0; JUPDATE = 0; JSEL = 0;
  endtask

  task automatic shift_n(input int n, input logic [31:0] bits,
                         output logic [7:0] ta, output logic [7:0] tb);
    ta = '0; tb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge JTCK);
      if (i < 8) begin ta[i] = tdo_a; tb[i] = tdo_b; end
      JCE = 1; JSHIFT = 1; JTDI = bits[i]; JUPDATE = 0; JSEL = 0;
    end
  endtask

  task automatic upd_step(input bit ce, input bit upd, input bit sel,
                          input bit acc_a, input logic [7:0] da,
                          input bit acc_b, input logic [7:0] db);
    @(negedge JTCK);
    JCE = ce; JSHIFT = 0; JUPDATE = upd; JSEL = sel; JTDI = 0;
    @(posedge JTCK);
    if (acc_a) qa.push_back('{d: da, t: $time});
    if (acc_b) qb.push_back('{d: db, t: $time});
  endtask

  task automatic run_row(input int r, input vec_t v);
    logic [7:0] ta, tb, m;
    capture();
    shift_n(v.n, v.bits, ta, tb);
    upd_step(1'b0, v.upd, v.sel, v.acc_a, v.dout_a, v.acc_b, v.dout_b);
    idle(1);
    m = (v.n >= 8) ? 8'hFF : 8'((32'd1 << v.n) - 1);
    if (v.n > 0) begin
      chk($sformatf("r%0d_tdo_a", r), ta & m, v.tdo_a & m);
      chk($sformatf("r%0d_tdo_b", r), tb & m, v.tdo_b & m);
    end
    chk($sformatf("r%0d_dout_a", r), dout_a, v.dout_a);
    chk($sformatf("r%0d_lerr_a", r), lerr_a, v.lerr_a);
    chk($sformatf("r%0d_dout_b", r), dout_b, v.dout_b);
    idle(3);
    chk($sformatf("r%0d_sdata_a", r), sdata_a, v.dout_a);
    chk($sformatf("r%0d_sdata_b", r), sdata_b, v.dout_b);
  endtask

  initial begin
    logic [7:0] ta, tb;
    //            n   bits          upd   sel   tdo_a  tdo_b  dout_a lerr  acc_a dout_b acc_b
    vt[0]  = '{8,  32'hA5,     1'b1, 1'b1, 8'h81, 8'hC3, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1};
    vt[1]  = '{8,  32'h3C,     1'b1, 1'b1, 8'hA5, 8'hC3, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
    vt[2]  = '{8,  32'h00,     1'b1, 1'b1, 8'h3C, 8'hC3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vt[3]  = '{7,  32'h55,     1'b1, 1'b1, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0, 8'hAB, 1'b1};
    vt[4]  = '{8,  32'h96,     1'b1, 1'b1, 8'h00, 8'hC3, 8'h96, 1'b0, 1'b1, 8'h96, 1'b1};
    vt[5]  = '{12, 32'hB2D,    1'b1, 1'b1, 8'h96, 8'hC3, 8'h96, 1'b1, 1'b0, 8'hB2, 1'b1};
    vt[6]  = '{8,  32'h4E,     1'b1, 1'b0, 8'h96, 8'hC3, 8'h96, 1'b1, 1'b0, 8'hB2, 1'b0};
    vt[7]  = '{0,  32'h0,      1'b1, 1'b1, 8'h96, 8'hC3, 8'h96, 1'b1, 1'b0, 8'hC3, 1'b1};
    vt[8]  = '{24, 32'hABCDEF, 1'b1, 1'b1, 8'h96, 8'hC3, 8'h96, 1'b1, 1'b0, 8'hAB, 1'b1};
    vt[9]  = '{8,  32'h69,     1'b1, 1'b1, 8'h96, 8'hC3, 8'h69, 1'b0, 1'b1, 8'h69, 1'b1};
    vt[10] = '{5,  32'h16,     1'b1, 1'b1, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0, 8'hB6, 1'b1};

    #33;
    chk("rst_dout_a", dout_a, 8'h81);
    chk("rst_sdata_a", sdata_a, 8'h81);
    chk("rst_lerr_a", lerr_a, 1'b0);
    chk("rst_svld_a", svld_a, 1'b0);
    chk("rst_tdo_a", tdo_a, 1'b0);
    chk("rst_dout_b", dout_b, 8'h00);
    #40 JRSTN = 1'b1;
    idle(2);

    for (int r = 0; r < 10; r++) run_row(r, vt[r]);

    // Update and capture on the same edge: update takes the shifted value,
    // capture takes the pre-edge data_out.
    capture();
    shift_n(8, 32'h12, ta, tb);
    upd_step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 8'h12);
    shift_n(8, 32'h00, ta, tb);
    chk("sim_tdo_a", ta, 8'h69);
    chk("sim_tdo_b", tb, 8'hC3);
    chk("sim_dout_a", dout_a, 8'h12);
    chk("sim_dout_b", dout_b, 8'h12);
    chk("sim_lerr_a", lerr_a, 1'b0);
    upd_step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    idle(1);
    chk("sim2_dout_a", dout_a, 8'h00);
    chk("sim2_dout_b", dout_b, 8'h00);
    idle(3);

    run_row(10, vt[10]);

    // Reset in the middle of a shift
    capture();
    shift_n(3, 32'h7, ta, tb);
    @(posedge JTCK);
    #7;
    JRSTN = 1'b0; JCE = 0; JSHIFT = 0;
    #4;
    chk("mrst_dout_a", dout_a, 8'h81);
    chk("mrst_sdata_a", sdata_a, 8'h81);
    chk("mrst_lerr_a", lerr_a, 1'b0);
    chk("mrst_svld_a", svld_a, 1'b0);
    chk("mrst_tdo_a", tdo_a, 1'b0);
    chk("mrst_dout_b", dout_b, 8'h00);
    chk("mrst_sdata_b", sdata_b, 8'h00);
    #20 JRSTN = 1'b1;
    idle(10);

    // Count restarts at zero: 8 shifts with no capture must be accepted
    shift_n(8, 32'h5E, ta, tb);
    chk("post_tdo_a", ta, 8'h00);
    upd_step(1'b0, 1'b1, 1'b1, 1'b1, 8'h5E, 1'b1, 8'h5E);
    idle(1);
    chk("post_dout_a", dout_a, 8'h5E);
    chk("post_lerr_a", lerr_a, 1'b0);
    chk("post_dout_b", dout_b, 8'h5E);
    idle(5);
    chk("post_sdata_a", sdata_a, 8'h5E);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
